noc_xbar_scheduler: RTL and testbench
=====================================

# noc_xbar_scheduler

Sequencing controller for the 4-port bi-NoC router crossbar, which carries one input-to-output connection at a time. Arbitrates round-robin among input ports A–D (index 0–3) whose FIFO heads hold a flit, and drives the crossbar's `In_add`, `out_add`, `CNFG`, `LOAD` and one-hot output enables. Holds a connection for a whole packet, up to a burst limit, then re-arbitrates.

## Interface
- `MAX_BURST`, 8: maximum flits per grant; range 1–255.
- `WDOG_CYCLES`, 16: stall limit in cycles, used only with the watchdog build.
- `CLK` in 1: clock, rising edge.
- `RES` in 1: reset, synchronous, active-high.
- `req` in 4: bit i = input FIFO i has a head flit.
- `dest` in 8: `dest[2i+1:2i]` = requested output port of input i's head flit.
- `tail` in 4: bit i = input i's head flit is a packet tail.
- `out_rdy` in 4: bit j = output j can accept a flit this cycle.
- `In_add` out 2: selected input port, registered.
- `out_add` out 2: selected output port, registered.
- `CNFG` out 1: one-cycle crossbar configure strobe, registered.
- `LOAD` out 1: flit transfer strobe this cycle, combinational.
- `en` out 4: one-hot output enable, equal to `1<<out_add` while connected; registered.
- `grant` out 4: one-hot granted input, registered.
- `busy` out 1: high in every state except IDLE.
- `wdog_trip` out 1: one-cycle watchdog release pulse.

## Operation
- States are IDLE, SETUP, XFER and RELEASE.
- **Eligible:** input i is eligible when `req[i]` is high and `dest[i] != i`. A U-turn request is masked and never granted.
- **IDLE:** if any input is eligible, pick the first eligible input at or after `ptr`, scanning upward modulo 4.
  - Register `In_add` = winner and `out_add` = `dest[winner]`, then go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP:** for one cycle, `CNFG`=1, `grant`=`1<<In_add`, `en`=`1<<out_add`. Then go to XFER.
- **XFER:** `LOAD` = `req[In_add] & out_rdy[out_add]`.
  - On each LOAD, `beat` increments.
  - If LOAD and `tail[In_add]`, go to RELEASE.
  - Else if LOAD and `beat`==MAX_BURST-1, go to RELEASE. This is preemption: the rest of the packet re-arbitrates later.
  - A low `req` or low `out_rdy` holds XFER with no LOAD.
  - `dest` changes are ignored during XFER.
- **RELEASE:** for one cycle, `en`=0, `grant`=0, `beat`=0, `ptr`=`In_add`+1 (2-bit wrap, 3→0). Then go to IDLE.
- `In_add` and `out_add` hold their last values outside a connection.
- If tail and the burst limit coincide on the same LOAD, there is a single release; tail wins and nothing extra happens.
- MAX_BURST=1 releases after every flit.

## Timing
- **Reset values:**
  - State is IDLE; `ptr`=0 and `beat`=0.
  - `In_add`=0, `out_add`=0, `en`=0, `grant`=0, `CNFG`=0, `busy`=0, `wdog_trip`=0.
  - `LOAD`=0, because it is gated by `~RES` and by state.
- Reset mid-XFER aborts the connection on that edge. No LOAD occurs in the reset cycle.
- **Latency:** request seen in IDLE at edge n, giving SETUP at n+1 and the first possible LOAD at n+2.
  - Back-to-back flits: 1 per cycle.
  - Minimum per-grant overhead is 3 cycles (IDLE, SETUP, RELEASE).
- A request arriving during RELEASE is considered in the following IDLE cycle.
- `LOAD` is combinational in the same cycle as the `req` and `out_rdy` it depends on. The FIFO pops on the edge where `LOAD` is high.

## Configuration
- Macro `NOC_XBAR_WDOG_EN`.
- **Defined:**
  - In XFER, a stall counter counts consecutive cycles without LOAD and clears on LOAD.
  - When it reaches WDOG_CYCLES, the block goes to RELEASE and pulses `wdog_trip` high for 1 cycle, concurrent with RELEASE.
  - `ptr` advances normally.
- **Undefined:** no stall counter; XFER waits indefinitely; `wdog_trip` is tied 0.

## Test plan
- **Single packet:** reset, then `req`=0100 with C→B (`dest[5:4]`=1), `out_rdy`=1111, and a 3-flit packet with tail on the 3rd.
  - Required: `CNFG` pulse 1 cycle after `req`, then LOAD high 3 consecutive cycles with `In_add`=2, `out_add`=1, `en`=0010.
  - Then RELEASE, IDLE, `busy`=0.
- **Round-robin:** all four inputs request continuously with 1-flit tail packets and legal destinations.
  - Required: grant order A, B, C, D, A; `ptr` wraps 3→0.
- **U-turn mask:** `req`=0001 with `dest[1:0]`=0.
  - Required: stays IDLE, `busy`=0, no `CNFG`.
  - Then set `dest[1:0]`=3: granted with `out_add`=3.
- **Burst preemption:** MAX_BURST=4, input B sends a 6-flit packet to D, and input A requests to C.
  - Required: 4 LOADs for B, release, grant to C-side request A, then B resumes with the remaining 2 flits.
- **Backpressure and watchdog:** during XFER, drop `out_rdy[out_add]`.
  - Without the macro: no LOAD, state holds, resumes when `out_rdy` returns.
  - With `NOC_XBAR_WDOG_EN` and WDOG_CYCLES=16: `wdog_trip` pulses on the 16th stalled cycle and the block returns to IDLE.
- **Reset mid-XFER:** assert `RES` after the 2nd of 5 flits.
  - Required: next cycle all outputs are at reset values, `LOAD`=0 in the reset cycle, and `ptr`=0.

Source files
------------

// File: rtl/noc_xbar_scheduler.sv
// ---------------------------------------------------------------------------
// noc_xbar_scheduler
//
// This is the sequencing controller for the 4-port bi-NoC router crossbar.
// The crossbar carries one input-to-output connection at a time.
//
// Arbitration:
//   - Input ports A-D (index 0-3) are arbitrated round-robin.
//   - An input takes part only when its FIFO head holds a flit.
//   - U-turn requests (destination == own index) are masked.
//
// Connection lifetime:
//   - A connection is held for a whole packet, or until MAX_BURST flits have
//     moved, whichever comes first.
//   - After that the controller releases the crossbar and arbitrates again.
//
// State sequence: IDLE -> SETUP -> XFER -> RELEASE -> IDLE.
//
// Optional build macro: NOC_XBAR_WDOG_EN
//   - Defined: a stall watchdog in XFER releases a connection that has made
//     no progress for WDOG_CYCLES consecutive cycles. It pulses wdog_trip
//     when it does so.
//   - Undefined: XFER waits indefinitely and wdog_trip is tied low.
//
// Parameters:
//   MAX_BURST    maximum flits per grant (1..255)
//   WDOG_CYCLES  stall limit in cycles (watchdog build only)
//
// Ports:
//   CLK        in   clock, rising edge
//   RES        in   synchronous active-high reset
//   req[3:0]   in   bit i: input FIFO i has a head flit
//   dest[7:0]  in   dest[2i+1:2i]: requested output of input i's head flit
//   tail[3:0]  in   bit i: input i's head flit is a packet tail
//   out_rdy    in   bit j: output j can accept a flit this cycle
//   In_add     out  selected input port (registered)
//   out_add    out  selected output port (registered)
//   CNFG       out  one-cycle crossbar configure strobe (registered)
//   LOAD       out  flit transfer strobe (combinational); the FIFO pops on
//                   the edge where LOAD is high
//   en[3:0]    out  one-hot output enable while connected (registered)
//   grant[3:0] out  one-hot granted input (registered)
//   busy       out  high in every state except IDLE
//   wdog_trip  out  one-cycle watchdog release pulse
// ---------------------------------------------------------------------------
module noc_xbar_scheduler #(
  parameter int MAX_BURST   = 8,
  parameter int WDOG_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic [3:0] req,
  input  logic [7:0] dest,
  input  logic [3:0] tail,
  input  logic [3:0] out_rdy,
  output logic [1:0] In_add,
  output logic [1:0] out_add,
  output logic       CNFG,
  output logic       LOAD,
  output logic [3:0] en,
  output logic [3:0] grant,
  output logic       busy,
  output logic       wdog_trip
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] XFER    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // Beat index of the last flit allowed in one grant.
  localparam logic [7:0] BEAT_LAST = 8'(MAX_BURST - 1);

  // -------------------------------------------------------------------------
  // Registers and internal signals
  // -------------------------------------------------------------------------
  logic [1:0] state;
  logic [1:0] ptr;        // round-robin start point for the next arbitration
  logic [7:0] beat;       // flits moved in the current grant

  logic [3:0] eligible;
  logic       win_valid;
  logic [1:0] win_idx;
  logic [1:0] win_dest;
  logic [1:0] cand;

  logic       beat_last;
  logic       release_now;
  logic       wdog_hit;

  // -------------------------------------------------------------------------
  // Eligibility: a head flit is present and the request is not a U-turn.
  // -------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb is given a default before any
  // conditional code, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = req[i] && (dest[2*i +: 2] != 2'(i));
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: the first eligible input at or after ptr, modulo 4.
  //
  // The loop scans from the farthest candidate down to ptr itself, so the
  // nearest eligible candidate is the last one written and therefore wins.
  // -------------------------------------------------------------------------
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (eligible[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_dest = dest[{win_idx, 1'b0} +: 2];

  // -------------------------------------------------------------------------
  // Transfer strobe.
  //
  // The strobe is combinational so that the FIFO pop and the crossbar
  // transfer happen in the same cycle as the req/out_rdy they depend on.
  // Gating with ~RES guarantees that no flit moves on a reset edge.
  // -------------------------------------------------------------------------
  assign LOAD = ~RES & (state == XFER) & req[In_add] & out_rdy[out_add];
  assign busy = (state != IDLE);

  // -------------------------------------------------------------------------
  // Release conditions.
  //
  // A tail flit and the burst limit may coincide on the same LOAD. Both lead
  // to the same single release, so they are simply OR-ed together.
  // -------------------------------------------------------------------------
  assign beat_last   = (beat == BEAT_LAST);
  assign release_now = (LOAD && (tail[In_add] || beat_last)) || wdog_hit;

  // -------------------------------------------------------------------------
  // Optional stall watchdog
  // -------------------------------------------------------------------------
`ifdef NOC_XBAR_WDOG_EN
  localparam int SW = $clog2(WDOG_CYCLES + 1);

  logic [SW-1:0] stall;

  // The trip fires on the WDOG_CYCLES-th consecutive cycle without LOAD.
  // It takes effect on that cycle's edge, so wdog_trip is high together
  // with RELEASE.
  assign wdog_hit = (state == XFER) && !LOAD && (stall == SW'(WDOG_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RES) begin
      stall     <= '0;
      wdog_trip <= 1'b0;
    end else begin
      wdog_trip <= wdog_hit;
      if ((state != XFER) || LOAD || wdog_hit) begin
        stall <= '0;
      end else begin
        stall <= stall + 1'b1;
      end
    end
  end
`else
  // Watchdog compiled out: XFER waits indefinitely for req and out_rdy.
  // WDOG_CYCLES remains in the parameter list so that both builds share one
  // instantiation. Here it only feeds a constant-false term.
  assign wdog_hit  = (WDOG_CYCLES < 0);
  assign wdog_trip = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Sequencer.
  //
  // In_add and out_add are written only when a new connection is granted.
  // They therefore hold their last values between connections.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments, so every
  // right-hand side sees pre-edge values regardless of statement order. A
  // later assignment to the same register (beat on release) simply wins.
  always_ff @(posedge CLK) begin
    if (RES) begin
      // NOTE: this block holds only a handful of control flops, so all of
      // them are reset. Aborting a connection mid-XFER leaves nothing stale.
      state   <= IDLE;
      ptr     <= 2'd0;
      beat    <= 8'd0;
      In_add  <= 2'd0;
      out_add <= 2'd0;
      CNFG    <= 1'b0;
      en      <= 4'd0;
      grant   <= 4'd0;
    end else begin
      CNFG <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            In_add  <= win_idx;
            out_add <= win_dest;
            CNFG    <= 1'b1;
            grant   <= 4'b0001 << win_idx;
            en      <= 4'b0001 << win_dest;
            state   <= SETUP;
          end
        end

        SETUP: begin
          state <= XFER;
        end

        XFER: begin
          if (LOAD) begin
            beat <= beat + 8'd1;
          end
          if (release_now) begin
            // Drop the connection for the RELEASE cycle. ptr moves past the
            // served input; the 2-bit add wraps 3 -> 0 naturally.
            en    <= 4'd0;
            grant <= 4'd0;
            beat  <= 8'd0;
            ptr   <= In_add + 2'd1;
            state <= RELEASE;
          end
        end

        RELEASE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_xbar_scheduler.sv
// ---------------------------------------------------------------------------
// tb_noc_xbar_scheduler
//
// Directed bench for noc_xbar_scheduler, built with MAX_BURST=4 and
// WDOG_CYCLES=16.
//
// Drive and sample timing:
//   - Inputs are driven 1 time unit after each rising edge.
//   - Outputs are sampled 1 time unit later, before the next edge.
//
// What each check compares:
//   - The registered outputs reflect the current state.
//   - LOAD reflects the current state together with the freshly driven
//     inputs.
//   - All outputs are packed into one vector:
//       {In_add, out_add, CNFG, LOAD, en, grant, busy, wdog_trip}
//   - That vector is compared against a hand-computed expectation.
// ---------------------------------------------------------------------------
module tb_noc_xbar_scheduler;

  logic       CLK = 1'b0;
  logic       RES;
  logic [3:0] req;
  logic [7:0] dest;
  logic [3:0] tail;
  logic [3:0] out_rdy;
  logic [1:0] In_add;
  logic [1:0] out_add;
  logic       CNFG;
  logic       LOAD;
  logic [3:0] en;
  logic [3:0] grant;
  logic       busy;
  logic       wdog_trip;

  int n_checks = 0;
  int n_errors = 0;

  noc_xbar_scheduler #(
    .MAX_BURST   (4),
    .WDOG_CYCLES (16)
  ) dut (
    .CLK       (CLK),
    .RES       (RES),
    .req       (req),
    .dest      (dest),
    .tail      (tail),
    .out_rdy   (out_rdy),
    .In_add    (In_add),
    .out_add   (out_add),
    .CNFG      (CNFG),
    .LOAD      (LOAD),
    .en        (en),
    .grant     (grant),
    .busy      (busy),
    .wdog_trip (wdog_trip)
  );

  always #5 CLK = ~CLK;

  logic [15:0] obs;
  assign obs = {In_add, out_add, CNFG, LOAD, en, grant, busy, wdog_trip};

  // Pack an expected output vector from small integers.
  function automatic logic [15:0] v(input int i, input int o, input int c,
                                    input int l, input int e, input int g,
                                    input int b, input int w);
    return {2'(i), 2'(o), 1'(c), 1'(l), 4'(e), 4'(g), 1'(b), 1'(w)};
  endfunction

  // Compare the current outputs against the expectation, then advance to
  // just after the next rising edge.
  task automatic step(input string tag, input logic [15:0] exp);
    #1;
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed {in,out,cnfg,load,en,grant,busy,wdog}=%h expected=%h",
             tag, obs, exp);
    end
    @(posedge CLK);
    #1;
  endtask

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int w;
    int o;
    int pi;
    int po;

    RES     = 1'b1;
    req     = 4'd0;
    dest    = 8'd0;
    tail    = 4'd0;
    out_rdy = 4'd0;
    @(posedge CLK);
    #1;

    // ---------------- Reset values ----------------
    step("reset_hold", v(0, 0, 0, 0, 0, 0, 0, 0));
    RES = 1'b0;
    step("reset_out", v(0, 0, 0, 0, 0, 0, 0, 0));

    // ---------------- Single packet: C -> B, 3 flits ----------------
    req     = 4'b0100;
    dest    = 8'h10;
    out_rdy = 4'hF;
    tail    = 4'd0;
    step("pkt_idle",    v(0, 0, 0, 0, 0, 0, 0, 0));
    step("pkt_setup",   v(2, 1, 1, 0, 4'b0010, 4'b0100, 1, 0));
    step("pkt_flit1",   v(2, 1, 0, 1, 4'b0010, 4'b0100, 1, 0));
    step("pkt_flit2",   v(2, 1, 0, 1, 4'b0010, 4'b0100, 1, 0));
    tail = 4'b0100;
    step("pkt_flit3",   v(2, 1, 0, 1, 4'b0010, 4'b0100, 1, 0));
    req  = 4'd0;
    tail = 4'd0;
    step("pkt_release", v(2, 1, 0, 0, 0, 0, 1, 0));
    step("pkt_idle2",   v(2, 1, 0, 0, 0, 0, 0, 0));

    // Reset again so that ptr restarts at 0 for the round-robin sequence.
    RES = 1'b1;
    step("rst2_hold", v(2, 1, 0, 0, 0, 0, 0, 0));
    RES = 1'b0;
    step("rst2_out",  v(0, 0, 0, 0, 0, 0, 0, 0));

    // ---------------- Round-robin: A,B,C,D,A; each input sends to index+1 ----------------
    req  = 4'hF;
    dest = 8'h39;
    tail = 4'hF;
    pi   = 0;
    po   = 0;
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      o = (w + 1) % 4;
      step($sformatf("rr%0d_idle", k),    v(pi, po, 0, 0, 0, 0, 0, 0));
      step($sformatf("rr%0d_setup", k),   v(w, o, 1, 0, 1 << o, 1 << w, 1, 0));
      step($sformatf("rr%0d_xfer", k),    v(w, o, 0, 1, 1 << o, 1 << w, 1, 0));
      step($sformatf("rr%0d_release", k), v(w, o, 0, 0, 0, 0, 1, 0));
      pi = w;
      po = o;
    end
    // Now ptr=1 and the last connection was A -> B.

    // ---------------- U-turn mask ----------------
    req  = 4'b0001;
    dest = 8'h00;
    tail = 4'd0;
    for (int k = 0; k < 3; k++) begin
      step("uturn_idle", v(0, 1, 0, 0, 0, 0, 0, 0));
    end
    dest = 8'h03;
    step("uturn_fix_idle", v(0, 1, 0, 0, 0, 0, 0, 0));
    step("uturn_setup",    v(0, 3, 1, 0, 4'b1000, 4'b0001, 1, 0));

    // ---------------- Backpressure: out_rdy[3] low in XFER ----------------
    out_rdy = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      step("bp_stall", v(0, 3, 0, 0, 4'b1000, 4'b0001, 1, 0));
    end
    out_rdy = 4'hF;
    tail    = 4'b0001;
    step("bp_resume",  v(0, 3, 0, 1, 4'b1000, 4'b0001, 1, 0));
    req  = 4'd0;
    tail = 4'd0;
    step("bp_release", v(0, 3, 0, 0, 0, 0, 1, 0));
    step("bp_idle",    v(0, 3, 0, 0, 0, 0, 0, 0));
    // ptr=1

    // ---------------- Burst preemption: B -> D, 6 flits; A -> C ----------------
    req  = 4'b0011;
    dest = 8'h0E;
    tail = 4'd0;
    step("burst_idle",  v(0, 3, 0, 0, 0, 0, 0, 0));
    step("burst_setup", v(1, 3, 1, 0, 4'b1000, 4'b0010, 1, 0));
    for (int k = 0; k < 4; k++) begin
      step($sformatf("burst_flit%0d", k + 1), v(1, 3, 0, 1, 4'b1000, 4'b0010, 1, 0));
    end
    step("burst_preempt", v(1, 3, 0, 0, 0, 0, 1, 0));
    // ptr=2 now, so A is picked ahead of the still-requesting B.
    step("burst_idle2",   v(1, 3, 0, 0, 0, 0, 0, 0));
    step("a_setup",       v(0, 2, 1, 0, 4'b0100, 4'b0001, 1, 0));
    tail = 4'b0001;
    step("a_flit",        v(0, 2, 0, 1, 4'b0100, 4'b0001, 1, 0));
    req  = 4'b0010;
    tail = 4'd0;
    step("a_release",     v(0, 2, 0, 0, 0, 0, 1, 0));
    step("b_idle",        v(0, 2, 0, 0, 0, 0, 0, 0));
    step("b_setup",       v(1, 3, 1, 0, 4'b1000, 4'b0010, 1, 0));
    step("b_flit5",       v(1, 3, 0, 1, 4'b1000, 4'b0010, 1, 0));
    tail = 4'b0010;
    step("b_flit6",       v(1, 3, 0, 1, 4'b1000, 4'b0010, 1, 0));
    req  = 4'd0;
    tail = 4'd0;
    step("b_release",     v(1, 3, 0, 0, 0, 0, 1, 0));
    step("b_idle_done",   v(1, 3, 0, 0, 0, 0, 0, 0));
    // ptr=2

    // ---------------- Reset mid-XFER: D -> A, reset after flit 2 ----------------
    req  = 4'b1000;
    dest = 8'h00;
    step("rx_idle",  v(1, 3, 0, 0, 0, 0, 0, 0));
    step("rx_setup", v(3, 0, 1, 0, 4'b0001, 4'b1000, 1, 0));
    step("rx_flit1", v(3, 0, 0, 1, 4'b0001, 4'b1000, 1, 0));
    step("rx_flit2", v(3, 0, 0, 1, 4'b0001, 4'b1000, 1, 0));
    RES = 1'b1;
    step("rx_reset_cycle", v(3, 0, 0, 0, 4'b0001, 4'b1000, 1, 0));
    RES  = 1'b0;
    req  = 4'b1001;
    dest = 8'h01;
    step("rx_after_reset", v(0, 0, 0, 0, 0, 0, 0, 0));
    // With ptr back at 0, A wins over D.
    step("rx_ptr0_setup",  v(0, 1, 1, 0, 4'b0010, 4'b0001, 1, 0));
    tail = 4'b0001;
    step("rx_a_flit",      v(0, 1, 0, 1, 4'b0010, 4'b0001, 1, 0));
    req  = 4'd0;
    tail = 4'd0;
    step("rx_a_release",   v(0, 1, 0, 0, 0, 0, 1, 0));
    step("rx_idle_done",   v(0, 1, 0, 0, 0, 0, 0, 0));

    // ---------------- Long stall: A -> B with out_rdy[1] low ----------------
    req     = 4'b0001;
    dest    = 8'h01;
    out_rdy = 4'b1101;
    step("wd_idle",  v(0, 1, 0, 0, 0, 0, 0, 0));
    step("wd_setup", v(0, 1, 1, 0, 4'b0010, 4'b0001, 1, 0));
`ifdef NOC_XBAR_WDOG_EN
    for (int k = 0; k < 16; k++) begin
      step($sformatf("wd_stall%0d", k + 1), v(0, 1, 0, 0, 4'b0010, 4'b0001, 1, 0));
    end
    req = 4'd0;
    step("wd_trip",       v(0, 1, 0, 0, 0, 0, 1, 1));
    step("wd_idle_after", v(0, 1, 0, 0, 0, 0, 0, 0));
`else
    for (int k = 0; k < 20; k++) begin
      step($sformatf("hold_stall%0d", k + 1), v(0, 1, 0, 0, 4'b0010, 4'b0001, 1, 0));
    end
    out_rdy = 4'hF;
    tail    = 4'b0001;
    step("hold_resume",  v(0, 1, 0, 1, 4'b0010, 4'b0001, 1, 0));
    req  = 4'd0;
    tail = 4'd0;
    step("hold_release", v(0, 1, 0, 0, 0, 0, 1, 0));
    step("hold_idle",    v(0, 1, 0, 0, 0, 0, 0, 0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
